// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI frame command sequencer driving a single-port synchronous RAM
// Optional ADDR_AUTOINC_EN: post-increment write/read addresses and keep reads armed for streaming.
module spi_ram_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [9:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err_seq,
  output logic              err_ovr,
  output logic              err_tmo,
  input  logic              err_clr
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_TX} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nx, rd_addr, rd_addr_nx;
  logic [7:0]        wdata_reg, wdata_nx, tx_data_nx;
  logic              rd_armed, rd_armed_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              seq_set, ovr_set, tmo_set;
  logic [1:0]        cmd;

  assign cmd  = rx_data[9:8];
  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx    = state;
    wr_addr_nx  = wr_addr;
    rd_addr_nx  = rd_addr;
    wdata_nx    = wdata_reg;
    tx_data_nx  = tx_data;
    rd_armed_nx = rd_armed;
    cnt_nx      = cnt;
    seq_set     = 1'b0;
    ovr_set     = 1'b0;
    tmo_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          case (cmd)
            2'b00: wr_addr_nx = rx_data[ADDR_W-1:0];
            2'b01: begin
              wdata_nx = rx_data[7:0];
              state_nx = S_WR;
            end
            2'b10: begin
              rd_addr_nx  = rx_data[ADDR_W-1:0];
              rd_armed_nx = 1'b1;
            end
            default: begin
              if (rd_armed) state_nx = S_RD_REQ;
              else          seq_set  = 1'b1;
            end
          endcase
        end
      end
      S_WR: begin
        state_nx = S_IDLE;
`ifdef ADDR_AUTOINC_EN
        wr_addr_nx = wr_addr + 1'b1;
`endif
      end
      S_RD_REQ: begin
        cnt_nx   = '0;
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // rvalid is checked first so it wins over the final timeout count
        if (mem_rvalid) begin
          tx_data_nx = mem_rdata;
          state_nx   = S_TX;
        end else if (cnt == TMO_LAST) begin
          tmo_set     = 1'b1;
          rd_armed_nx = 1'b0;
          state_nx    = S_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_TX: begin
        state_nx = S_IDLE;
`ifdef ADDR_AUTOINC_EN
        rd_addr_nx = rd_addr + 1'b1;
`else
        rd_armed_nx = 1'b0;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
    if (rx_valid && state != S_IDLE) ovr_set = 1'b1;
  end

  // Strobes are registered from the next state so they line up with WR/RD_REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      wdata_reg <= '0;
      rd_armed  <= 1'b0;
      cnt       <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_seq   <= 1'b0;
      err_ovr   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_addr   <= wr_addr_nx;
      rd_addr   <= rd_addr_nx;
      wdata_reg <= wdata_nx;
      rd_armed  <= rd_armed_nx;
      cnt       <= cnt_nx;
      tx_valid  <= (state_nx == S_TX);
      tx_data   <= tx_data_nx;
      mem_en    <= (state_nx == S_WR) || (state_nx == S_RD_REQ);
      mem_we    <= (state_nx == S_WR);
      mem_addr  <= (state_nx == S_WR) ? wr_addr_nx : rd_addr_nx;
      mem_wdata <= wdata_nx;
      err_seq   <= seq_set | (err_seq & ~err_clr);
      err_ovr   <= ovr_set | (err_ovr & ~err_clr);
      err_tmo   <= tmo_set | (err_tmo & ~err_clr);
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - scoreboard bench for spi_ram_ctrl with a variable-latency RAM model
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [9:0] rx_data = '0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_rvalid = 1'b0;
  logic       busy, err_seq, err_ovr, err_tmo;
  logic       err_clr = 1'b0;

  spi_ram_ctrl #(.ADDR_W(8), .RD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .busy(busy), .err_seq(err_seq), .err_ovr(err_ovr),
    .err_tmo(err_tmo), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       kind;   // 0 write strobe, 1 read strobe, 2 tx byte
    int       cyc;
    bit [7:0] addr;
    bit [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  rd_lat  = 1;
  int  pend    = 0;
  logic [7:0] ram [256];
  logic [7:0] raddr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RAM model: rd_lat cycles from read strobe to rvalid; rd_lat==0 never answers
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ram[raddr];
      end
    end
    if (!rst && mem_en && !mem_we && rd_lat > 0) begin
      pend  = rd_lat;
      raddr = mem_addr;
    end
    if (!rst && mem_en && mem_we) ram[mem_addr] = mem_wdata;
  end

  // Monitor: every strobe/tx pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && (mem_en || tx_valid)) begin
      ev_t e;
      int  k;
      k = tx_valid ? 2 : (mem_we ? 0 : 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event_kind", k, 32'hFF);
      end else begin
        e = exp_q.pop_front();
        chk("ev_kind", k, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        if (k == 2) chk("tx_data", tx_data, e.data);
        else        chk("mem_addr", mem_addr, e.addr);
        if (k == 0) chk("mem_wdata", mem_wdata, e.data);
      end
    end
  end

  task automatic push(input int kind, input int c, input bit [7:0] a, input bit [7:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit [1:0] c, input bit [7:0] p, output int t);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = {c, p};
    t = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic clear_errs();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"},
        {tx_valid, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, err_seq, err_ovr, err_tmo},
        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Write then read with 1-cycle RAM latency
    rd_lat = 1;
    send(2'b00, 8'h12, t);
    send(2'b01, 8'hA5, t); push(0, t + 1, 8'h12, 8'hA5);
    idle(3);
    send(2'b10, 8'h12, t);
    send(2'b11, 8'h00, t); push(1, t + 1, 8'h12, 8'h00); push(2, t + 3, 8'h00, 8'hA5);
    idle(5);
    chk("wr_rd_tx_data_held", tx_data, 8'hA5);
    chk("wr_rd_no_errors", {err_seq, err_ovr, err_tmo}, 3'b000);

    // Read without arming
    do_reset();
    send(2'b11, 8'h00, t);
    chk("unarmed_busy", busy, 1'b0);
    chk("unarmed_err_seq", err_seq, 1'b1);
    idle(3);
    chk("unarmed_busy_later", busy, 1'b0);
    clear_errs();
    chk("err_clr_seq", err_seq, 1'b0);

    // Timeout: RAM never answers
    rd_lat = 0;
    send(2'b10, 8'h30, t);
    send(2'b11, 8'h00, t0); push(1, t0 + 1, 8'h30, 8'h00);
    idle(t0 + 17 - cyc);
    chk("tmo_busy_last_wait", busy, 1'b1);
    chk("tmo_not_yet", err_tmo, 1'b0);
    idle(1);
    chk("tmo_busy_done", busy, 1'b0);
    chk("tmo_err", err_tmo, 1'b1);
    send(2'b11, 8'h00, t);
    chk("tmo_disarmed_seq", err_seq, 1'b1);
    clear_errs();
    chk("tmo_err_cleared", {err_seq, err_tmo}, 2'b00);

    // Overrun during RD_WAIT
    rd_lat = 4;
    send(2'b00, 8'h50, t);
    send(2'b01, 8'h77, t); push(0, t + 1, 8'h50, 8'h77);
    idle(2);
    send(2'b00, 8'h60, t);
    send(2'b10, 8'h50, t);
    send(2'b11, 8'h00, t0); push(1, t0 + 1, 8'h50, 8'h00); push(2, t0 + 6, 8'h00, 8'h77);
    send(2'b00, 8'h99, t);
    chk("ovr_err", err_ovr, 1'b1);
    idle(6);
    chk("ovr_tx_done", tx_data, 8'h77);
    send(2'b01, 8'hBB, t); push(0, t + 1, 8'h60, 8'hBB);
    idle(3);
    clear_errs();

    // rvalid on the 16th RD_WAIT cycle still completes
    rd_lat = 16;
    send(2'b10, 8'h12, t);
    send(2'b11, 8'h00, t0); push(1, t0 + 1, 8'h12, 8'h00); push(2, t0 + 18, 8'h00, 8'hA5);
    idle(20);
    chk("edge_no_tmo", err_tmo, 1'b0);
    chk("edge_tx_data", tx_data, 8'hA5);

    // Reset during RD_WAIT aborts the read
    rd_lat = 3;
    send(2'b10, 8'h50, t);
    send(2'b11, 8'h00, t0); push(1, t0 + 1, 8'h50, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all_zero("midrd_reset");
    idle(2);
    rst = 1'b0;
    idle(10);
    chk("midrd_busy_after", busy, 1'b0);

`ifdef ADDR_AUTOINC_EN
    rd_lat = 1;
    send(2'b00, 8'hFF, t);
    send(2'b01, 8'h11, t); push(0, t + 1, 8'hFF, 8'h11);
    idle(2);
    send(2'b01, 8'h22, t); push(0, t + 1, 8'h00, 8'h22);
    idle(2);
    send(2'b10, 8'hFF, t);
    send(2'b11, 8'h00, t); push(1, t + 1, 8'hFF, 8'h00); push(2, t + 3, 8'h00, 8'h11);
    idle(4);
    send(2'b11, 8'h00, t); push(1, t + 1, 8'h00, 8'h00); push(2, t + 3, 8'h00, 8'h22);
    idle(4);
    chk("autoinc_no_seq", err_seq, 1'b0);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command sequencer between the SPI slave frame interface (10-bit rx word, 8-bit tx byte) and a single-port synchronous RAM.
- Decodes the 2-bit command in each received frame and keeps separate write/read address registers.
- Issues single-cycle RAM strobes, waits for read data with a timeout, and returns the byte to the slave's tx path.
- Flags protocol violations in sticky error bits.

Parameters:
- ADDR_W, 8, RAM address width (1..8); taken from rx_data[ADDR_W-1:0].
- RD_TIMEOUT, 16, max cycles in RD_WAIT without mem_rvalid before abort (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete frame
- rx_data  in  10  [9:8]=cmd, [7:0]=payload
- tx_valid  out  1  one-cycle pulse: tx_data holds read byte
- tx_data  out  8  last read byte, held until next read completes
- mem_en  out  1  RAM access strobe, one cycle
- mem_we  out  1  1=write, 0=read; valid with mem_en
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, sampled when mem_rvalid=1
- mem_rvalid  in  1  read data valid, latency >=1 after mem_en
- busy  out  1  high whenever state != IDLE
- err_seq  out  1  sticky: read-data cmd with no armed read address
- err_ovr  out  1  sticky: rx_valid arrived while busy
- err_tmo  out  1  sticky: read timed out
- err_clr  in  1  clears all sticky errors

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; wr_addr=rd_addr=0; rd_armed=0; timeout counter=0.
- States: IDLE, WR, RD_REQ, RD_WAIT, TX.
- Command decode, IDLE with rx_valid=1:
  - cmd 00: wr_addr<=payload; stay IDLE.
  - cmd 01: wdata_reg<=payload; go WR.
  - cmd 10: rd_addr<=payload; rd_armed<=1; stay IDLE.
  - cmd 11: if rd_armed, go RD_REQ (payload ignored); else set err_seq and stay IDLE.
- WR: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wdata_reg for exactly one cycle -> IDLE.
- RD_REQ: mem_en=1, mem_we=0, mem_addr=rd_addr for one cycle; clear counter -> RD_WAIT.
- RD_WAIT:
  - mem_rvalid=1: tx_data<=mem_rdata -> TX.
  - Otherwise counter++; when counter reaches RD_TIMEOUT without rvalid: set err_tmo, rd_armed<=0, -> IDLE, no tx_valid.
  - rvalid on the same cycle as the final count wins (no timeout).
- TX: tx_valid=1 for one cycle; rd_armed<=0 -> IDLE.
- Latency, rx_valid at cycle T:
  - write: mem_en at T+1.
  - read: mem_en at T+1; tx_valid at T+3 with rvalid at T+2 (minimum).
- mem_en/mem_we are 0 outside WR/RD_REQ; mem_addr/mem_wdata are don't-care when mem_en=0. Outputs are registered.
- rx_valid in any state other than IDLE: frame dropped, no register changes, err_ovr set.
- mem_rvalid outside RD_WAIT is ignored.
- err_clr clears all three error bits; a set event in the same cycle wins (bit reads 1 next cycle).
- Reset mid-transaction aborts immediately; no further mem_en or tx_valid.

Optional Feature:
- Macro: ADDR_AUTOINC_EN.
- Defined:
  - After each WR strobe, wr_addr increments mod 2^ADDR_W.
  - After each successful TX, rd_addr increments mod 2^ADDR_W and rd_armed stays 1, so back-to-back cmd 11 frames stream sequential bytes.
  - Timeout still clears rd_armed.
- Not defined: addresses are only changed by cmd 00/10; rd_armed is cleared after every read.

Test Plan:
- Write then read: frames 00_0x12, 01_0xA5, 10_0x12, 11_0x00 with RAM model latency 1 -> one write strobe at addr 0x12 data 0xA5; read strobe at addr 0x12; tx_valid pulse with tx_data=0xA5, 3 cycles after the last rx_valid.
- Read without arming: after reset send 11_0x00 -> no mem_en, err_seq=1, busy stays 0; err_clr pulse -> err_seq=0.
- Timeout: RAM never asserts rvalid, RD_TIMEOUT=16 -> exactly 16 RD_WAIT cycles, err_tmo=1, no tx_valid, next 11 frame sets err_seq.
- Overrun: rx_valid pulse during RD_WAIT -> frame ignored (wr_addr unchanged), err_ovr=1, read completes normally.
- Boundaries: rvalid on the 16th RD_WAIT cycle -> tx_valid, err_tmo=0; rst asserted in RD_WAIT -> all outputs 0 immediately, no tx_valid after release.
- ADDR_AUTOINC_EN: 00_0xFF, then 01_0x11, 01_0x22 -> writes at 0xFF then 0x00; 10_0xFF, 11, 11 -> tx_data 0x11 then 0x22.
